// File: rtl/mem_copy_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module  : mem_copy_pkg
//  Purpose : Shared types for the memory copy engine.
//            copy_state_t encodes the engine's four-state control sequence.
//  Revision: 1.0  initial release
// ============================================================================
package mem_copy_pkg;

  // IDLE  : waiting for Start
  // READ  : source byte on the bus, captured into the hold register
  // WRITE : hold register driven to the destination with write enable
  // DONE  : one-cycle completion pulse
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } copy_state_t;

endpackage : mem_copy_pkg
`default_nettype wire

// File: rtl/mem_copy_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module  : mem_copy_engine
//  Purpose : Bus initiator that copies Length bytes from SrcAddr to DstAddr
//            in a single-port memory with combinational reads. Each byte
//            takes one READ cycle followed by one WRITE cycle on the shared
//            address pointer.
//  Ports   : Clk, Reset        - clock, synchronous active-high reset
//            Start             - copy request, honoured only while idle
//            SrcAddr/DstAddr   - first source / destination address
//            Length            - byte count (0 = no-op, completes at once)
//            Busy, Done        - in-progress flag, one-cycle completion pulse
//            MemAddress        - memory address (source or destination)
//            MemWriteEn        - memory write enable (WRITE cycles only)
//            MemWrData         - memory write data (zero outside WRITE)
//            MemRdData         - combinational memory read data
//  Revision: 1.0  initial release
// ============================================================================
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int W = 8,
  parameter int A = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [A-1:0] SrcAddr,
  input  logic [A-1:0] DstAddr,
  input  logic [A-1:0] Length,
  output logic         Busy,
  output logic         Done,
  output logic [A-1:0] MemAddress,
  output logic         MemWriteEn,
  output logic [W-1:0] MemWrData,
  input  logic [W-1:0] MemRdData
);

  copy_state_t  state_q, state_d;
  logic [A-1:0] src_q,   src_d;
  logic [A-1:0] dst_q,   dst_d;
  logic [A-1:0] rem_q,   rem_d;
  logic [W-1:0] hold_q,  hold_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state and output decode. Every output depends only on registered
  // state and pointers, so the memory sees stable values for a whole cycle.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    rem_d      = rem_q;
    hold_d     = hold_q;
    Busy       = 1'b0;
    Done       = 1'b0;
    MemAddress = '0;
    MemWriteEn = 1'b0;
    MemWrData  = '0;

    case (state_q)
      IDLE: begin
        if (Start) begin
          src_d   = SrcAddr;
          dst_d   = DstAddr;
          rem_d   = Length;
          state_d = (Length != '0) ? READ : DONE;
        end
      end

      READ: begin
        Busy       = 1'b1;
        MemAddress = src_q;
        hold_d     = MemRdData;
        src_d      = src_q + A'(1);   // wraps naturally at 2**A
        state_d    = WRITE;
      end

      WRITE: begin
        Busy       = 1'b1;
        MemAddress = dst_q;
        MemWrData  = hold_q;
        MemWriteEn = 1'b1;
        dst_d      = dst_q + A'(1);
        rem_d      = rem_q - A'(1);
        // rem_q still counts the byte being written now
        state_d    = (rem_q > A'(1)) ? READ : DONE;
      end

      DONE: begin
        Busy    = 1'b1;
        Done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule : mem_copy_engine
`default_nettype wire

// File: tb/tb_mem_copy_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module  : tb_mem_copy_engine
//  Purpose : Directed self-checking bench for mem_copy_engine with a
//            behavioural 256 x 8 single-port memory as the responder.
//  Revision: 1.0  initial release
// ============================================================================
module tb_mem_copy_engine;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic [7:0] SrcAddr, DstAddr, Length;
  logic       Busy, Done, MemWriteEn;
  logic [7:0] MemAddress, MemWrData, MemRdData;

  // Memory with a bench-side preload port
  logic [7:0] mem [256];
  logic       pl_en   = 1'b0;
  logic [7:0] pl_addr = '0;
  logic [7:0] pl_data = '0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 Clk = ~Clk;

  assign MemRdData = mem[MemAddress];

  always @(posedge Clk) begin
    if (pl_en)           mem[pl_addr]    <= pl_data;
    else if (MemWriteEn) mem[MemAddress] <= MemWrData;
  end

  mem_copy_engine #(.W(8), .A(8)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .SrcAddr    (SrcAddr),
    .DstAddr    (DstAddr),
    .Length     (Length),
    .Busy       (Busy),
    .Done       (Done),
    .MemAddress (MemAddress),
    .MemWriteEn (MemWriteEn),
    .MemWrData  (MemWrData),
    .MemRdData  (MemRdData)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  // Issue one copy and observe it cycle by cycle. Sample j is taken in
  // cycle k+j, where k is the edge that accepts Start.
  task automatic run_copy(
    input  logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
    input  int inj_cyc, input int rst_cyc,
    output int done_at, output int n_done, output int n_busy,
    output int n_wr, output int bad_wd, output int we_after_rst, output int to);
    done_at = 0; n_done = 0; n_busy = 0; n_wr = 0; bad_wd = 0;
    we_after_rst = 0; to = 1;
    Start = 1'b1; SrcAddr = s; DstAddr = d; Length = l;
    tick();
    Start = 1'b0;
    for (int j = 1; j <= 600; j++) begin
      if (Done) begin
        n_done++;
        if (done_at == 0) done_at = j;
      end
      if (Busy)       n_busy++;
      if (MemWriteEn) n_wr++;
      if (!MemWriteEn && MemWrData !== 8'h00) bad_wd++;
      if (rst_cyc != 0 && j == rst_cyc + 1) we_after_rst = int'(MemWriteEn);
      if (inj_cyc != 0 && j == inj_cyc) begin
        Start = 1'b1; SrcAddr = 8'h50; DstAddr = 8'hC0; Length = 8'd2;
      end
      if (inj_cyc != 0 && j == inj_cyc + 1) Start = 1'b0;
      if (rst_cyc != 0 && j == rst_cyc)     Reset = 1'b1;
      if (rst_cyc != 0 && j == rst_cyc + 1) Reset = 1'b0;
      if (!Busy) begin
        to = 0;
        break;
      end
      tick();
    end
  endtask

  int done_at, n_done, n_busy, n_wr, bad_wd, we_rst, to;

  initial begin
    Reset = 1'b1; Start = 1'b0;
    SrcAddr = '0; DstAddr = '0; Length = '0;
    tick(); tick();

    // Reset state
    check("rst_busy",  {31'd0, Busy},       32'd0);
    check("rst_done",  {31'd0, Done},       32'd0);
    check("rst_we",    {31'd0, MemWriteEn}, 32'd0);
    check("rst_addr",  {24'd0, MemAddress}, 32'd0);
    check("rst_wdata", {24'd0, MemWrData},  32'd0);
    Reset = 1'b0;

    for (int i = 0; i < 256; i++) preload(8'(i), 8'hEE);

    // Basic copy
    preload(8'h10, 8'hA1); preload(8'h11, 8'hB2);
    preload(8'h12, 8'hC3); preload(8'h13, 8'hD4);
    run_copy(8'h10, 8'h80, 8'd4, 0, 0, done_at, n_done, n_busy, n_wr, bad_wd, we_rst, to);
    check("basic_to",      to,      0);
    check("basic_done_at", done_at, 9);
    check("basic_n_done",  n_done,  1);
    check("basic_busy",    n_busy,  9);
    check("basic_writes",  n_wr,    4);
    check("basic_wdata0",  bad_wd,  0);
    check("basic_m80", {24'd0, mem[8'h80]}, 32'hA1);
    check("basic_m81", {24'd0, mem[8'h81]}, 32'hB2);
    check("basic_m82", {24'd0, mem[8'h82]}, 32'hC3);
    check("basic_m83", {24'd0, mem[8'h83]}, 32'hD4);
    check("basic_m84", {24'd0, mem[8'h84]}, 32'hEE);

    // Zero length
    run_copy(8'h10, 8'h90, 8'd0, 0, 0, done_at, n_done, n_busy, n_wr, bad_wd, we_rst, to);
    check("zero_to",      to,      0);
    check("zero_done_at", done_at, 1);
    check("zero_busy",    n_busy,  1);
    check("zero_writes",  n_wr,    0);
    check("zero_m90", {24'd0, mem[8'h90]}, 32'hEE);

    // Wrap-around source
    preload(8'hFE, 8'h11); preload(8'hFF, 8'h22);
    preload(8'h00, 8'h33); preload(8'h01, 8'h44);
    run_copy(8'hFE, 8'h40, 8'd4, 0, 0, done_at, n_done, n_busy, n_wr, bad_wd, we_rst, to);
    check("wrap_done_at", done_at, 9);
    check("wrap_m40", {24'd0, mem[8'h40]}, 32'h11);
    check("wrap_m41", {24'd0, mem[8'h41]}, 32'h22);
    check("wrap_m42", {24'd0, mem[8'h42]}, 32'h33);
    check("wrap_m43", {24'd0, mem[8'h43]}, 32'h44);

    // Wrap-around destination; dst overlaps src so 0x11 replicates forward
    run_copy(8'hFE, 8'hFF, 8'd4, 0, 0, done_at, n_done, n_busy, n_wr, bad_wd, we_rst, to);
    check("wrap2_writes", n_wr, 4);
    check("wrap2_mFF", {24'd0, mem[8'hFF]}, 32'h11);
    check("wrap2_m00", {24'd0, mem[8'h00]}, 32'h11);
    check("wrap2_m01", {24'd0, mem[8'h01]}, 32'h11);
    check("wrap2_m02", {24'd0, mem[8'h02]}, 32'h11);
    check("wrap2_m03", {24'd0, mem[8'h03]}, 32'hEE);

    // Start while busy is ignored
    preload(8'h50, 8'h5A); preload(8'h51, 8'h5B);
    run_copy(8'h10, 8'hA0, 8'd4, 3, 0, done_at, n_done, n_busy, n_wr, bad_wd, we_rst, to);
    check("busy_done_at", done_at, 9);
    check("busy_n_done",  n_done,  1);
    check("busy_writes",  n_wr,    4);
    check("busy_mA3", {24'd0, mem[8'hA3]}, 32'hD4);
    check("busy_mC0", {24'd0, mem[8'hC0]}, 32'hEE);
    check("busy_mC1", {24'd0, mem[8'hC1]}, 32'hEE);
    tick();
    check("busy_idle_after", {31'd0, Busy}, 32'd0);

    // Reset mid-copy in cycle 5
    run_copy(8'h10, 8'hB0, 8'd4, 0, 5, done_at, n_done, n_busy, n_wr, bad_wd, we_rst, to);
    check("rstmid_to",     to,     0);
    check("rstmid_we",     we_rst, 0);
    check("rstmid_writes", n_wr,   2);
    check("rstmid_n_done", n_done, 0);
    check("rstmid_mB0", {24'd0, mem[8'hB0]}, 32'hA1);
    check("rstmid_mB1", {24'd0, mem[8'hB1]}, 32'hB2);
    check("rstmid_mB2", {24'd0, mem[8'hB2]}, 32'hEE);

    // Normal copy after the reset
    run_copy(8'h12, 8'hD0, 8'd2, 0, 0, done_at, n_done, n_busy, n_wr, bad_wd, we_rst, to);
    check("post_done_at", done_at, 5);
    check("post_mD0", {24'd0, mem[8'hD0]}, 32'hC3);
    check("post_mD1", {24'd0, mem[8'hD1]}, 32'hD4);

    // Overlapping ascending copy
    preload(8'h20, 8'h01); preload(8'h21, 8'h02); preload(8'h22, 8'h03);
    run_copy(8'h20, 8'h21, 8'd3, 0, 0, done_at, n_done, n_busy, n_wr, bad_wd, we_rst, to);
    check("ovl_done_at", done_at, 7);
    check("ovl_m20", {24'd0, mem[8'h20]}, 32'h01);
    check("ovl_m21", {24'd0, mem[8'h21]}, 32'h01);
    check("ovl_m22", {24'd0, mem[8'h22]}, 32'h01);
    check("ovl_m23", {24'd0, mem[8'h23]}, 32'h01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_mem_copy_engine
`default_nettype wire

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
Bus-initiator block that drives the single-port data memory to copy a block of bytes from a source address range to a destination range. It sits between the controller (which issues Start with addresses and length) and the data memory's address/write-enable/data pins. The memory has combinational reads and writes on the clock edge through one shared address pointer, so the engine alternates one read cycle and one write cycle per byte.

Parameters:
W, 8, data width in bits; must match the data memory width
A, 8, address width; memory depth is 2**A

Ports:
Clk  input  1  system clock; all state updates on posedge
Reset  input  1  synchronous, active-high reset
Start  input  1  request a copy; sampled only in IDLE
SrcAddr  input  A  first source address; latched on an accepted Start
DstAddr  input  A  first destination address; latched on an accepted Start
Length  input  A  byte count; latched on an accepted Start; 0 = no-op
Busy  output  1  high while a copy is in progress (READ, WRITE, DONE)
Done  output  1  one-cycle pulse when the copy completes
MemAddress  output  A  drives memory DataAddress
MemWriteEn  output  1  drives memory WriteEn
MemWrData  output  W  drives memory DataIn
MemRdData  input  W  from memory DataOut (combinational read data)

Behaviour:
- States: IDLE, READ, WRITE, DONE.
- Reset (sync): state=IDLE; src/dst pointers, remaining count and hold register cleared; Busy=0, Done=0, MemWriteEn=0, MemAddress=0, MemWrData=0.
- IDLE: outputs as in reset. If Start=1 at a posedge, latch SrcAddr/DstAddr/Length. If Length!=0 go to READ, else go to DONE.
- READ: MemAddress=src pointer, MemWriteEn=0. At the posedge, capture MemRdData into the hold register, increment src modulo 2**A, and go to WRITE.
- WRITE: MemAddress=dst pointer, MemWrData=hold, MemWriteEn=1 for exactly this cycle. At the posedge, increment dst modulo 2**A and decrement the remaining count. Go to READ if remaining>1, else go to DONE.
- DONE: Done=1, Busy=1, MemWriteEn=0 for one cycle, then go to IDLE.
- All memory-side outputs and Busy/Done are decoded from registered state and pointers, so they are glitch-free and valid for the whole cycle. MemWrData=0 outside WRITE.
- Latency: for Start accepted at edge k, Done is high during cycle k+2L+1 (L=Length). L=0 gives Done in cycle k+1 with no memory writes. Busy is high for 2L+1 cycles.
- Start while Busy: ignored. Start is accepted again in IDLE, i.e. no earlier than the cycle after Done.
- Address wrap: pointers wrap 2**A-1 -> 0 with no error.
- Overlap: the copy is strictly ascending. If dst lies in (src, src+L), the result is forward replication. This is defined behaviour and is not corrected.
- Reset mid-copy: takes effect at the next posedge. MemWriteEn is 0 from that cycle on. Bytes already written stay written, no Done is issued, and the state returns to IDLE.
- Maximum copy length is 2**A-1 bytes.

Decomposition:
- Package mem_copy_pkg: typedef enum logic [1:0] copy_state_t {IDLE, READ, WRITE, DONE}.
- Single module with no sub-module. Pointer, counter and hold registers live in one always_ff block; output decode is in one always_comb block.
- The bench instantiates the existing data memory as the responder.

Test Plan:
- Basic copy: preload mem[0x10..0x13]=0xA1,0xB2,0xC3,0xD4; Start Src=0x10 Dst=0x80 Len=4 -> mem[0x80..0x83] match the source; Done pulses once, exactly 9 cycles after the Start edge; Busy is high for 9 cycles.
- Zero length: Start Len=0 -> Done in the next cycle, MemWriteEn never asserted, memory unchanged.
- Wrap-around: mem[0xFE]=0x11, [0xFF]=0x22, [0x00]=0x33, [0x01]=0x44; Src=0xFE Dst=0x40 Len=4 -> mem[0x40..0x43]=0x11,0x22,0x33,0x44. Repeat with Dst=0xFF: writes land at 0xFF,0x00,0x01,0x02.
- Start during Busy: pulse Start with different addresses in cycle 3 of a Len=4 copy -> the request is ignored; only the original destination is written; one Done pulse.
- Reset mid-copy: assert Reset in cycle 5 of a Len=4 copy -> MemWriteEn is 0 from the next cycle; exactly 2 destination bytes are written; Busy=0, Done never pulses; a following Start works normally.
- Overlap: mem[0x20..0x22]=0x01,0x02,0x03; Src=0x20 Dst=0x21 Len=3 -> mem[0x21..0x23]=0x01,0x01,0x01.
